// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the serial system-bus arbiter.
//   arb_state_e : arbiter sequencing states
//   err_code_t  : error code reported on err_code
//   DEFAULT_*   : default slave-ID width and timeout used by bus_arbiter
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ID_RX   = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_TIMEOUT = 2'b01;
  localparam err_code_t ERR_BAD_SID = 2'b10;
  localparam err_code_t ERR_ABORT   = 2'b11;

  localparam int DEFAULT_SID_W   = 2;
  localparam int DEFAULT_TIMEOUT = 255;
  // Timeout counter is fixed at 8 bits, so TIMEOUT must stay within 1..255.
  localparam int TIMEOUT_CNT_W   = 8;

endpackage

// File: rtl/bus_arbiter_if.sv
// Handshake bundle between the bus masters/slaves and the arbiter.
//   master modport : request side (drives requests, serial IDs, slave done pulses)
//   slave modport  : arbiter side (drives grant, mux selects, busy and error status)
interface bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  import bus_arb_pkg::*;

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] m_req;
  logic [NUM_MASTERS-1:0] m_sid_bit;
  logic [NUM_MASTERS-1:0] m_sid_valid;
  logic [NUM_SLAVES-1:0]  s_done;
  logic [NUM_MASTERS-1:0] m_grant;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_SLAVES-1:0]  s_sel;
  logic                   bus_busy;
  logic                   err_pulse;
  err_code_t              err_code;

  modport master (
    output m_req, m_sid_bit, m_sid_valid, s_done,
    input  m_grant, grant_idx, s_sel, bus_busy, err_pulse, err_code
  );

  modport slave (
    input  m_req, m_sid_bit, m_sid_valid, s_done,
    output m_grant, grant_idx, s_sel, bus_busy, err_pulse, err_code
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set bit of req_i searching upward
// from ptr_i with wrap-around.
//   req_i   : request vector
//   ptr_i   : search start index (must be < N)
//   grant_o : one-hot winner (zero when no request)
//   idx_o   : winner index
//   valid_o : any request present
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);
  localparam int CW = IDX_W + 1;

  logic [CW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = {1'b0, ptr_i} + CW'(off);
      if (cand >= CW'(N)) begin
        cand = cand - CW'(N);
      end
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        valid_o                    = 1'b1;
        grant_o[cand[IDX_W-1:0]]   = 1'b1;
        idx_o                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central serial-bus arbiter: round-robin grant, serial slave-ID decode,
// hold until the selected slave completes, then a one-cycle release.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : slave modport of bus_arbiter_if (requests, IDs, done in;
//           grant, grant_idx, s_sel, bus_busy, err_pulse, err_code out)
module bus_arbiter import bus_arb_pkg::*; #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SID_W       = DEFAULT_SID_W,
  parameter int TIMEOUT     = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);
  localparam int IDX_W     = $clog2(NUM_MASTERS);
  localparam int BIT_CNT_W = $clog2(SID_W + 1);

  arb_state_e                 state_q;
  logic [NUM_MASTERS-1:0]     m_grant_q;
  logic [IDX_W-1:0]           grant_idx_q;
  logic [IDX_W-1:0]           rr_ptr_q;
  logic [NUM_SLAVES-1:0]      s_sel_q;
  logic                       bus_busy_q;
  logic                       err_pulse_q;
  err_code_t                  err_code_q;
  logic [SID_W-1:0]           sid_q;
  logic [BIT_CNT_W-1:0]       bit_cnt_q;
  logic [TIMEOUT_CNT_W-1:0]   timeout_cnt_q;

  logic [NUM_MASTERS-1:0]     pick_grant;
  logic [IDX_W-1:0]           pick_idx;
  logic                       pick_valid;

  logic [SID_W-1:0]           sid_d;
  logic [BIT_CNT_W-1:0]       bit_cnt_d;
  logic [TIMEOUT_CNT_W-1:0]   timeout_cnt_d;
  logic [IDX_W-1:0]           rr_ptr_d;
  logic [NUM_SLAVES-1:0]      sel_onehot;
  logic                       sid_strobe;
  logic                       last_bit;
  logic                       sid_ok;
  logic                       done_ev;
  logic                       err_ev;
  err_code_t                  err_val;

  rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_picker (
    .req_i   (bus.m_req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    // Only the granted master's ID line is observed.
    sid_strobe    = bus.m_sid_valid[grant_idx_q];
    sid_d         = SID_W'({sid_q, bus.m_sid_bit[grant_idx_q]});
    bit_cnt_d     = bit_cnt_q + BIT_CNT_W'(1);
    last_bit      = (bit_cnt_d == BIT_CNT_W'(SID_W));
    sid_ok        = int'(sid_d) < NUM_SLAVES;
    sel_onehot    = NUM_SLAVES'(1) << sid_d;
    timeout_cnt_d = timeout_cnt_q + TIMEOUT_CNT_W'(1);
    rr_ptr_d      = (int'(grant_idx_q) == NUM_MASTERS - 1) ? '0 : grant_idx_q + IDX_W'(1);
    done_ev       = (state_q == ACTIVE) && |(bus.s_done & s_sel_q);

    // Completion beats abort, abort beats timeout; a bad ID is the weakest.
    err_ev  = 1'b0;
    err_val = ERR_NONE;
    if (!done_ev) begin
      if (!bus.m_req[grant_idx_q]) begin
        err_ev  = 1'b1;
        err_val = ERR_ABORT;
      end else if (timeout_cnt_d == TIMEOUT_CNT_W'(TIMEOUT)) begin
        err_ev  = 1'b1;
        err_val = ERR_TIMEOUT;
      end else if ((state_q == ID_RX) && sid_strobe && last_bit && !sid_ok) begin
        err_ev  = 1'b1;
        err_val = ERR_BAD_SID;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      m_grant_q     <= '0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      s_sel_q       <= '0;
      bus_busy_q    <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_code_q    <= ERR_NONE;
      sid_q         <= '0;
      bit_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            m_grant_q     <= pick_grant;
            grant_idx_q   <= pick_idx;
            sid_q         <= '0;
            bit_cnt_q     <= '0;
            timeout_cnt_q <= '0;
            bus_busy_q    <= 1'b1;
            state_q       <= ID_RX;
          end
        end
        ID_RX, ACTIVE: begin
          timeout_cnt_q <= timeout_cnt_d;
          if (done_ev || err_ev) begin
            m_grant_q   <= '0;
            s_sel_q     <= '0;
            err_pulse_q <= err_ev;
            if (err_ev) begin
              err_code_q <= err_val;
            end
            state_q <= RELEASE;
          end else if ((state_q == ID_RX) && sid_strobe) begin
            sid_q     <= sid_d;
            bit_cnt_q <= bit_cnt_d;
            if (last_bit) begin
              s_sel_q <= sel_onehot;
              state_q <= ACTIVE;
            end
          end
        end
        RELEASE: begin
          // Turnaround cycle: bus still marked busy, pointer moves past the last owner.
          rr_ptr_q   <= rr_ptr_d;
          bus_busy_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_grant   = m_grant_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.s_sel     = s_sel_q;
  assign bus.bus_busy  = bus_busy_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle checks plus a scoreboard of
// expected transaction outcomes compared at each release cycle.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  localparam int NM = 2;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus ();

  bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .SID_W(SW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [NM-1:0] grant;
    logic [NS-1:0] sel;
    logic          err;
    logic [1:0]    code;
  } txn_t;

  txn_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rr_m     = 0;

  logic [NM-1:0] mon_grant;
  logic [NS-1:0] mon_sel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [NM-1:0] g, input logic [NS-1:0] s, input logic e, input logic [1:0] c);
    txn_t t;
    t.grant = g;
    t.sel   = s;
    t.err   = e;
    t.code  = c;
    sb_q.push_back(t);
  endtask

  task automatic sb_compare(input logic [NM-1:0] g, input logic [NS-1:0] s, input logic e, input logic [1:0] c);
    txn_t t;
    $display("txn @%0t: grant=%b sel=%b err=%0b code=%b", $time, g, s, e, c);
    check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      t = sb_q.pop_front();
      check_eq("sb_grant", 32'(g), 32'(t.grant));
      check_eq("sb_sel", 32'(s), 32'(t.sel));
      check_eq("sb_err", 32'(e), 32'(t.err));
      if (t.err) check_eq("sb_code", 32'(c), 32'(t.code));
    end
  endtask

  // Monitor: track grant/select through a transaction, score it at RELEASE
  // (busy high with grant and select both cleared).
  always @(negedge clk) begin
    if (reset || !bus.bus_busy) begin
      mon_grant <= '0;
      mon_sel   <= '0;
    end else if (bus.m_grant == '0 && bus.s_sel == '0) begin
      sb_compare(mon_grant, mon_sel, bus.err_pulse, bus.err_code);
    end else begin
      if (bus.m_grant != '0) mon_grant <= bus.m_grant;
      if (bus.s_sel != '0) mon_sel <= bus.s_sel;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sid(input int m, input int sid);
    for (int b = SW - 1; b >= 0; b--) begin
      bus.m_sid_valid[m] = 1'b1;
      bus.m_sid_bit[m]   = sid[b];
      tick();
    end
    bus.m_sid_valid[m] = 1'b0;
    bus.m_sid_bit[m]   = 1'b0;
  endtask

  task automatic wait_grant(input string tag, output int cycles);
    cycles = 0;
    while (bus.m_grant == '0 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_eq(tag, 32'(bus.m_grant != '0), 32'd1);
  endtask

  task automatic release_idle();
    bus.m_req = '0;
    tick();
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int win;
    reset           = 1'b1;
    bus.m_req       = '0;
    bus.m_sid_bit   = '0;
    bus.m_sid_valid = '0;
    bus.s_done      = '0;
    repeat (3) tick();
    check_eq("rst_grant", 32'(bus.m_grant), 32'd0);
    check_eq("rst_idx", 32'(bus.grant_idx), 32'd0);
    check_eq("rst_sel", 32'(bus.s_sel), 32'd0);
    check_eq("rst_busy", 32'(bus.bus_busy), 32'd0);
    check_eq("rst_errp", 32'(bus.err_pulse), 32'd0);
    check_eq("rst_code", 32'(bus.err_code), 32'(ERR_NONE));
    reset = 1'b0;

    // Single master, sid=1; master1 strobes noise that must be ignored.
    bus.m_req          = 2'b01;
    bus.m_sid_valid[1] = 1'b1;
    bus.m_sid_bit[1]   = 1'b1;
    push_exp(2'b01, 3'b010, 1'b0, ERR_NONE);
    tick();
    check_eq("t1_grant", 32'(bus.m_grant), 32'h1);
    check_eq("t1_busy", 32'(bus.bus_busy), 32'd1);
    send_sid(0, 1);
    bus.m_sid_valid[1] = 1'b0;
    bus.m_sid_bit[1]   = 1'b0;
    check_eq("t1_sel", 32'(bus.s_sel), 32'h2);
    repeat (9) tick();
    bus.s_done = 3'b010;
    tick();
    bus.s_done = '0;
    bus.m_req  = '0;
    check_eq("t1_rel_grant", 32'(bus.m_grant), 32'd0);
    check_eq("t1_rel_sel", 32'(bus.s_sel), 32'd0);
    check_eq("t1_rel_busy", 32'(bus.bus_busy), 32'd1);
    tick();
    check_eq("t1_idle_busy", 32'(bus.bus_busy), 32'd0);

    // Round-robin with both masters requesting continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr_m  = 0;
    bus.m_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      win = rr_m;
      push_exp(NM'(1) << win, 3'b001, 1'b0, ERR_NONE);
      wait_grant("t2_grant_seen", cyc);
      check_eq("t2_latency", 32'(cyc), (i == 0) ? 32'd1 : 32'd2);
      check_eq("t2_grant", 32'(bus.m_grant), 32'(NM'(1) << win));
      send_sid(win, 0);
      bus.s_done = 3'b001;
      tick();
      bus.s_done = '0;
      rr_m = (win + 1) % NM;
    end
    release_idle();

    // Bad slave ID from master1.
    bus.m_req = 2'b10;
    push_exp(2'b10, 3'b000, 1'b1, ERR_BAD_SID);
    wait_grant("t3_grant_seen", cyc);
    check_eq("t3_idx", 32'(bus.grant_idx), 32'd1);
    send_sid(1, 3);
    check_eq("t3_errp", 32'(bus.err_pulse), 32'd1);
    check_eq("t3_code", 32'(bus.err_code), 32'(ERR_BAD_SID));
    check_eq("t3_sel", 32'(bus.s_sel), 32'd0);
    check_eq("t3_grant", 32'(bus.m_grant), 32'd0);
    bus.m_req = '0;
    tick();
    check_eq("t3_errp_1cyc", 32'(bus.err_pulse), 32'd0);
    check_eq("t3_code_hold", 32'(bus.err_code), 32'(ERR_BAD_SID));
    tick();
    rr_m = 0;

    // Timeout: sid=2 accepted, slave never completes.
    bus.m_req = 2'b01;
    push_exp(2'b01, 3'b100, 1'b1, ERR_TIMEOUT);
    wait_grant("t4_grant_seen", cyc);
    send_sid(0, 2);
    check_eq("t4_sel", 32'(bus.s_sel), 32'h4);
    k = 2;
    while (!bus.err_pulse && k < 40) begin
      tick();
      k++;
    end
    check_eq("t4_cycles", 32'(k), 32'(TO));
    check_eq("t4_code", 32'(bus.err_code), 32'(ERR_TIMEOUT));
    check_eq("t4_sel_clr", 32'(bus.s_sel), 32'd0);
    release_idle();

    // Master abort mid-ACTIVE.
    bus.m_req = 2'b01;
    push_exp(2'b01, 3'b010, 1'b1, ERR_ABORT);
    wait_grant("t5a_grant_seen", cyc);
    send_sid(0, 1);
    repeat (3) tick();
    bus.m_req = '0;
    tick();
    check_eq("t5a_errp", 32'(bus.err_pulse), 32'd1);
    check_eq("t5a_code", 32'(bus.err_code), 32'(ERR_ABORT));
    check_eq("t5a_grant", 32'(bus.m_grant), 32'd0);
    tick();
    tick();

    // Done coincident with request drop; unselected done ignored first.
    bus.m_req = 2'b01;
    push_exp(2'b01, 3'b100, 1'b0, ERR_NONE);
    wait_grant("t5b_grant_seen", cyc);
    send_sid(0, 2);
    bus.s_done = 3'b001;
    tick();
    bus.s_done = '0;
    check_eq("t5b_unsel_done", 32'(bus.s_sel), 32'h4);
    bus.m_req  = '0;
    bus.s_done = 3'b100;
    tick();
    bus.s_done = '0;
    check_eq("t5b_no_errp", 32'(bus.err_pulse), 32'd0);
    check_eq("t5b_grant", 32'(bus.m_grant), 32'd0);
    check_eq("t5b_code_hold", 32'(bus.err_code), 32'(ERR_ABORT));
    tick();
    tick();
    rr_m = 1;

    // Reset while slave 0 is selected.
    bus.m_req = 2'b01;
    wait_grant("t6_grant_seen", cyc);
    send_sid(0, 0);
    check_eq("t6_sel", 32'(bus.s_sel), 32'h1);
    reset = 1'b1;
    tick();
    check_eq("t6_grant", 32'(bus.m_grant), 32'd0);
    check_eq("t6_idx", 32'(bus.grant_idx), 32'd0);
    check_eq("t6_sel_clr", 32'(bus.s_sel), 32'd0);
    check_eq("t6_busy", 32'(bus.bus_busy), 32'd0);
    check_eq("t6_errp", 32'(bus.err_pulse), 32'd0);
    check_eq("t6_code", 32'(bus.err_code), 32'(ERR_NONE));
    reset     = 1'b0;
    bus.m_req = 2'b11;
    rr_m      = 0;
    push_exp(2'b01, 3'b010, 1'b0, ERR_NONE);
    wait_grant("t6_regrant_seen", cyc);
    check_eq("t6_rr_ptr", 32'(bus.m_grant), 32'(NM'(1) << rr_m));
    send_sid(0, 1);
    bus.s_done = 3'b010;
    tick();
    bus.s_done = '0;
    release_idle();

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
